keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan sequencer for the 4-row x 3-column candy-selection keypad. Drives one-hot
//  column strobes, synchronises and debounces the row lines, and emits a single
//  key-press event with a 4-bit key code. Sits between the keypad pins and the
//  vending selection FSM, replacing free-running column drive with a press/release
//  handshake.
// PARAMETERS
//  SCAN_DIV      250000  clk cycles each column is strobed while scanning (>=4)
//  DEBOUNCE_CNT  500000  consecutive stable clk cycles required for press/release (>=2)
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset      in   1  asynchronous, active-high reset
//  row        in   4  keypad row lines, active-high, asynchronous to clk
//  col        out  3  one-hot column strobe, active-high
//  key_code   out  4  code of last accepted key: row_idx*3 + col_idx (0..11)
//  key_valid  out  1  one-cycle pulse when key_code is newly accepted
//  key_held   out  1  high from accept until debounced release
// BEHAVIOUR
//  Reset (async assert, sync release): col=3'b001, key_code=0, key_valid=0,
//   key_held=0, state=SCAN, counters=0, synchroniser flops=0.
//  row passes through a 2-flop synchroniser (row_s). All decisions use row_s only.
//  FSM states:
//   SCAN    : col rotates 001->010->100->001, SCAN_DIV cycles per column. In the last
//             cycle of a dwell, if row_s has exactly one bit set: latch row_idx and
//             col_idx, go to DEBOUNCE, and freeze col. Otherwise advance col.
//             Zero or multiple row bits set -> no key.
//   DEBOUNCE: col frozen; counter counts cycles with row_s == latched row. Any mismatch
//             -> SCAN, continuing from the next column, no event. Reaching
//             DEBOUNCE_CNT -> PRESSED; in the same edge key_code is updated, key_valid
//             pulses 1 cycle, and key_held goes 1.
//   PRESSED : col frozen; counter counts consecutive cycles with row_s == 0; any
//             nonzero row_s clears the counter. Reaching DEBOUNCE_CNT -> SCAN,
//             key_held=0, col advances to the next column.
//  key_code holds its value until the next accept; it is not cleared on release.
//  key_valid never asserts twice for one press; a held key yields exactly one event.
//  A second key pressed while PRESSED is ignored until full release.
//  Worst-case latency, stable press to key_valid:
//   3*SCAN_DIV + 2 + DEBOUNCE_CNT + 1 cycles.
//  Counters are sized $clog2(max(SCAN_DIV,DEBOUNCE_CNT))+1 bits; there is no wrap.
//   Each counter clears on every state entry.
//  Reset mid-operation: immediate return to reset values. A pending press produces
//   no event.
//  col is always exactly one-hot and is never 000, including in reset.
// STRUCTURE
//  Shared package keypad_pkg:
//   - state encoding ST_SCAN/ST_DEBOUNCE/ST_PRESSED (2 bits)
//   - NUM_ROWS=4, NUM_COLS=3
//   - key constants KEY_STAR=9, KEY_0=10, KEY_HASH=11
//  One sub-module, kp_row_sync: 2-flop synchroniser plus onehot4 check; outputs
//   row_s, row_idx[1:0], row_single.
//  The FSM, the column rotator and the debounce counter live in keypad_scan_ctrl.
// TESTING (bench uses SCAN_DIV=4, DEBOUNCE_CNT=3, clk period 20 ns)
//  1 Reset, row=0: col=001 and key_valid=0 during reset; after release col cycles
//    001,010,100 with 4 cycles each.
//  2 Hold row=4'b0001 while col=010: one key_valid pulse with key_code=1 and
//    key_held=1; release for 3+ cycles: key_held=0, scanning resumes at col=100.
//  3 Hold row=4'b1000 while col=100 for 200 ns: exactly one pulse with key_code=11;
//    key_held stays high throughout.
//  4 Glitch row=4'b0010 for 2 cycles during DEBOUNCE: no key_valid; FSM back in SCAN.
//  5 Hold row=4'b0011 (two rows) across a full scan: no key_valid ever.
//  6 Assert reset while in PRESSED: all outputs return to reset values at once;
//    no pulse after release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
// Covers state encoding, keypad geometry, named key codes and small column helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } kp_state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0    = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic [1:0] col_to_idx(input logic [2:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    case (col)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // A rotate keeps the strobe one-hot without needing a separate index register.
  function automatic logic [2:0] next_col(input logic [2:0] col);
    return {col[1:0], col[2]};
  endfunction

  function automatic logic [3:0] key_of(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return ({2'b00, row_idx} * 4'd3) + {2'b00, col_idx};
  endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchroniser for the asynchronous row lines.
// Also flags whether exactly one row is active and which one it is.
module kp_row_sync
  import keypad_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_ROWS-1:0] i_row,
  output logic [NUM_ROWS-1:0] o_row_s,
  output logic [1:0]          o_row_idx,
  output logic                o_row_single
);

  logic [NUM_ROWS-1:0] r_meta;
  logic [NUM_ROWS-1:0] r_sync;
  logic [1:0]          w_idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_row;
      r_sync <= r_meta;
    end
  end

  // The index is only meaningful when o_row_single is high.
  always_comb begin
    w_idx = 2'd0;
    case (r_sync)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  assign o_row_s      = r_sync;
  assign o_row_idx    = w_idx;
  assign o_row_single = (r_sync != '0) && ((r_sync & (r_sync - 4'd1)) == '0);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scan, debounce and press/release sequencer for the 4x3 keypad.
// Emits one key_valid pulse per debounced press, and key_held stays high until a debounced release.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 250000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic [1:0]          o_dbg_state
);

  localparam int MAXV = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW   = $clog2(MAXV) + 1;

  logic [NUM_ROWS-1:0] w_row_s;
  logic [1:0]          w_row_idx;
  logic                w_row_single;
  logic                w_lat_match;

  kp_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_col, w_col_nxt;
  logic [1:0]    r_lat_row, w_lat_row_nxt;
  logic [3:0]    r_code, w_code_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_held, w_held_nxt;

  kp_row_sync u_row_sync (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_row        (row),
    .o_row_s      (w_row_s),
    .o_row_idx    (w_row_idx),
    .o_row_single (w_row_single)
  );

  assign w_lat_match = (w_row_s == (4'b0001 << r_lat_row));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_SCAN;
      r_cnt     <= '0;
      r_col     <= 3'b001;
      r_lat_row <= 2'd0;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_col     <= w_col_nxt;
      r_lat_row <= w_lat_row_nxt;
      r_code    <= w_code_nxt;
      r_valid   <= w_valid_nxt;
      r_held    <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_col_nxt     = r_col;
    w_lat_row_nxt = r_lat_row;
    w_code_nxt    = r_code;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_held;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == CW'(SCAN_DIV - 1)) begin
          w_cnt_nxt = '0;
          if (w_row_single) begin
            w_lat_row_nxt = w_row_idx;
            w_state_nxt   = ST_DEBOUNCE;
          end else begin
            w_col_nxt = next_col(r_col);
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        // Column stays frozen, so the current strobe is the latched column.
        if (!w_lat_match) begin
          w_state_nxt = ST_SCAN;
          w_col_nxt   = next_col(r_col);
          w_cnt_nxt   = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_code_nxt  = key_of(r_lat_row, col_to_idx(r_col));
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (w_row_s != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(DEBOUNCE_CNT - 1)) begin
          w_state_nxt = ST_SCAN;
          w_cnt_nxt   = '0;
          w_held_nxt  = 1'b0;
          w_col_nxt   = next_col(r_col);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
        w_cnt_nxt   = '0;
        w_col_nxt   = 3'b001;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  assign col         = r_col;
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_held    = r_held;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl with short scan/debounce periods.
// Expected key codes are queued at press time and retired by a monitor on each key_valid pulse.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int TMO          = 60;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int n_events = 0;

  keypad_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      n_events++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_key_valid", 32'(key_code), 32'hFFFF);
      end else begin
        check_eq("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
      check_eq("held_at_valid", 32'(key_held), 32'd1);
    end
  end

  // driver helpers
  task automatic wait_col_start(input logic [2:0] c);
    int n;
    n = 0;
    while (col == c && n < TMO) begin @(negedge clk); n++; end
    while (col != c && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("tmo_col_start", 32'(col), 32'(c));
  endtask

  task automatic wait_events(input int target);
    int n;
    n = 0;
    while (n_events < target && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("tmo_key_valid", 32'(n_events), 32'(target));
  endtask

  task automatic wait_held_low();
    int n;
    n = 0;
    while (key_held && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("tmo_release", 32'(key_held), 32'd0);
  endtask

  task automatic wait_state(input logic [1:0] s);
    int n;
    n = 0;
    while (dbg_state != s && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check_eq("tmo_state", 32'(dbg_state), 32'(s));
  endtask

  initial begin
    int base;
    reset = 1'b1;
    row   = 4'b0000;

    // 1: reset values, then column rotation
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_col", 32'(col), 32'b001);
      check_eq("rst_valid", 32'(key_valid), 32'd0);
      check_eq("rst_held", 32'(key_held), 32'd0);
      check_eq("rst_code", 32'(key_code), 32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'(ST_SCAN));
    end
    reset = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      check_eq($sformatf("scan_col_%0d", i), 32'(col), 32'(3'b001 << ((i / 4) % 3)));
      @(negedge clk);
    end

    // 2: row0 at col 010 -> code 1, release resumes at col 100
    wait_col_start(3'b010);
    base = n_events;
    exp_q.push_back(4'd1);
    row = 4'b0001;
    wait_events(base + 1);
    check_eq("t2_held", 32'(key_held), 32'd1);
    row = 4'b0000;
    wait_held_low();
    check_eq("t2_col_after_release", 32'(col), 32'b100);
    check_eq("t2_state", 32'(dbg_state), 32'(ST_SCAN));
    check_eq("t2_events", 32'(n_events), 32'(base + 1));

    // 3: row3 at col 100 held 200 ns -> single KEY_HASH event
    wait_col_start(3'b100);
    base = n_events;
    exp_q.push_back(KEY_HASH);
    row = 4'b1000;
    repeat (10) begin
      @(negedge clk);
      if (n_events > base) check_eq("t3_held_during", 32'(key_held), 32'd1);
    end
    row = 4'b0000;
    check_eq("t3_held_at_release", 32'(key_held), 32'd1);
    wait_held_low();
    check_eq("t3_events", 32'(n_events), 32'(base + 1));

    // 4: short glitch reaches DEBOUNCE but is rejected
    wait_col_start(3'b001);
    base = n_events;
    row = 4'b0010;
    wait_state(ST_DEBOUNCE);
    row = 4'b0000;
    wait_state(ST_SCAN);
    check_eq("t4_col_next", 32'(col), 32'b010);
    repeat (10) @(negedge clk);
    check_eq("t4_no_event", 32'(n_events), 32'(base));
    check_eq("t4_state", 32'(dbg_state), 32'(ST_SCAN));

    // 5: two rows active across several scans -> never a key
    base = n_events;
    row = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 10 == 0) check_eq("t5_state", 32'(dbg_state), 32'(ST_SCAN));
    end
    row = 4'b0000;
    repeat (4) @(negedge clk);
    check_eq("t5_no_event", 32'(n_events), 32'(base));
    check_eq("t5_col_onehot", 32'($countones(col)), 32'd1);

    // 6: reset while PRESSED
    wait_col_start(3'b010);
    base = n_events;
    exp_q.push_back(KEY_0);
    row = 4'b1000;
    wait_events(base + 1);
    check_eq("t6_pressed", 32'(dbg_state), 32'(ST_PRESSED));
    reset = 1'b1;
    #1;
    check_eq("t6_rst_col", 32'(col), 32'b001);
    check_eq("t6_rst_held", 32'(key_held), 32'd0);
    check_eq("t6_rst_valid", 32'(key_valid), 32'd0);
    check_eq("t6_rst_code", 32'(key_code), 32'd0);
    check_eq("t6_rst_state", 32'(dbg_state), 32'(ST_SCAN));
    repeat (2) @(negedge clk);
    row = 4'b0000;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_no_event", 32'(n_events), 32'(base + 1));
    check_eq("t6_held_low", 32'(key_held), 32'd0);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
